// File: rtl/lcd_window_ctrl.sv
// lcd_window_ctrl: decodes CASET/PASET/RAMWR from the SPI word stream and writes pixels into frame RAM.
// Optional build macro LCD_WINDOW_CTRL_SWRESET_EN enables opcode 0x01 (SWRESET).
module lcd_window_ctrl #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_mode,
    input  logic [15:0]       i_data,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [15:0]       o_wr_data,
    output logic              o_frame_done
);
    localparam int COL_W = $clog2(H_RES);
    localparam int ROW_W = $clog2(V_RES);
    localparam logic [COL_W-1:0]  COL_MAX = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0] H_STEP  = ADDR_W'(H_RES);

    typedef enum logic [2:0] {
        S_IDLE, S_CA0, S_CA1, S_PA0, S_PA1, S_CALC, S_WRITE
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  sc, ec, col;
    logic [ROW_W-1:0]  sp, ep, row;
    logic [ROW_W-1:0]  mul_a;
    logic [ADDR_W-1:0] mul_b, start_base, row_base;
    logic              wr_last;

    logic              in_xfer, wr_xfer;
    logic [COL_W-1:0]  arg_col;
    logic [ROW_W-1:0]  arg_row;

    // NOTE: o_ready is combinational so a draining write frees the slot in the same cycle.
    assign o_ready = (state != S_CALC) && (!o_wr_valid || i_wr_ready);
    assign in_xfer = i_valid && o_ready;
    assign wr_xfer = o_wr_valid && i_wr_ready;
    assign arg_col = (i_data > 16'(H_RES - 1)) ? COL_MAX : i_data[COL_W-1:0];
    assign arg_row = (i_data > 16'(V_RES - 1)) ? ROW_MAX : i_data[ROW_W-1:0];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= S_IDLE;
            sc           <= '0;
            ec           <= COL_MAX;
            sp           <= '0;
            ep           <= ROW_MAX;
            col          <= '0;
            row          <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            start_base   <= '0;
            row_base     <= '0;
            wr_last      <= 1'b0;
            o_wr_valid   <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= wr_xfer && wr_last;
            // NOTE: a pixel accepted in the same cycle assigns o_wr_valid again below; the later NBA wins.
            if (wr_xfer)
                o_wr_valid <= 1'b0;

            if (state == S_CALC) begin
                // Shift-add SP*H_RES once per RAMWR, keeping multipliers out of the pixel path.
                if (mul_a == '0) begin
                    row_base <= start_base;
                    state    <= S_WRITE;
                end else begin
                    if (mul_a[0])
                        start_base <= start_base + mul_b;
                    mul_a <= mul_a >> 1;
                    mul_b <= mul_b << 1;
                end
            end else if (in_xfer && i_mode) begin
                case (i_data[15:8])
                    8'h2A: state <= S_CA0;
                    8'h2B: state <= S_PA0;
                    8'h2C: begin
                        state      <= S_CALC;
                        col        <= sc;
                        row        <= sp;
                        mul_a      <= sp;
                        mul_b      <= H_STEP;
                        start_base <= '0;
                    end
`ifdef LCD_WINDOW_CTRL_SWRESET_EN
                    8'h01: begin
                        state <= S_IDLE;
                        sc    <= '0;
                        ec    <= COL_MAX;
                        sp    <= '0;
                        ep    <= ROW_MAX;
                        col   <= '0;
                        row   <= '0;
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end else if (in_xfer) begin
                case (state)
                    S_CA0: begin
                        sc <= arg_col;
                        if (arg_col > ec)
                            ec <= arg_col;
                        state <= S_CA1;
                    end
                    S_CA1: begin
                        ec    <= (arg_col < sc) ? sc : arg_col;
                        state <= S_IDLE;
                    end
                    S_PA0: begin
                        sp <= arg_row;
                        if (arg_row > ep)
                            ep <= arg_row;
                        state <= S_PA1;
                    end
                    S_PA1: begin
                        ep    <= (arg_row < sp) ? sp : arg_row;
                        state <= S_IDLE;
                    end
                    S_WRITE: begin
                        o_wr_valid <= 1'b1;
                        o_wr_data  <= i_data;
                        o_wr_addr  <= row_base + ADDR_W'(col);
                        wr_last    <= (col == ec) && (row == ep);
                        if (col == ec) begin
                            col <= sc;
                            if (row == ep) begin
                                row      <= sp;
                                row_base <= start_base;
                            end else begin
                                row      <= row + ROW_W'(1);
                                row_base <= row_base + H_STEP;
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_window_ctrl.sv
// Self-checking bench for lcd_window_ctrl: directed window tests plus random windows against an arithmetic model.
module tb_lcd_window_ctrl;
    localparam int H_RES  = 320;
    localparam int V_RES  = 240;
    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              reset, i_valid, i_mode, i_wr_ready;
    logic              o_ready, o_wr_valid, o_frame_done;
    logic [15:0]       i_data, o_wr_data;
    logic [ADDR_W-1:0] o_wr_addr;

    always #10 clk = ~clk;

    lcd_window_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_mode      (i_mode),
        .i_data      (i_data),
        .o_wr_valid  (o_wr_valid),
        .i_wr_ready  (i_wr_ready),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_frame_done(o_frame_done)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        logic              last;
    } wr_t;
    typedef enum {M_IDLE, M_CA0, M_CA1, M_PA0, M_PA1, M_WR} mstate_t;

    int                n_checks = 0;
    int                n_fail   = 0;
    wr_t               exp_q[$];
    mstate_t           m_st = M_IDLE;
    int                m_sc = 0, m_ec = H_RES - 1, m_sp = 0, m_ep = V_RES - 1, m_k = 0;
    int                exp_lasts = 0, done_cnt = 0;
    logic              exp_done = 1'b0;
    bit                mon_en = 1'b0;
    bit                rand_ready = 1'b0;
    logic [ADDR_W-1:0] last_addr;
    logic [15:0]       last_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int clampi(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset_window();
        m_sc = 0; m_ec = H_RES - 1; m_sp = 0; m_ep = V_RES - 1;
    endtask

    // Pixel k of a window lands at column SC + k mod W on row SP + (k div W) mod H.
    task automatic model_step(input logic mode, input logic [15:0] d, output bit pushed);
        int  w, h, v;
        wr_t e;
        pushed = 1'b0;
        if (mode) begin
            m_st = M_IDLE;
            case (d[15:8])
                8'h2A: m_st = M_CA0;
                8'h2B: m_st = M_PA0;
                8'h2C: begin m_st = M_WR; m_k = 0; end
`ifdef LCD_WINDOW_CTRL_SWRESET_EN
                8'h01: model_reset_window();
`endif
                default: ;
            endcase
        end else begin
            case (m_st)
                M_CA0: begin
                    m_sc = clampi(int'(d), H_RES - 1);
                    if (m_sc > m_ec) m_ec = m_sc;
                    m_st = M_CA1;
                end
                M_CA1: begin
                    v = clampi(int'(d), H_RES - 1);
                    m_ec = (v < m_sc) ? m_sc : v;
                    m_st = M_IDLE;
                end
                M_PA0: begin
                    m_sp = clampi(int'(d), V_RES - 1);
                    if (m_sp > m_ep) m_ep = m_sp;
                    m_st = M_PA1;
                end
                M_PA1: begin
                    v = clampi(int'(d), V_RES - 1);
                    m_ep = (v < m_sp) ? m_sp : v;
                    m_st = M_IDLE;
                end
                M_WR: begin
                    w = m_ec - m_sc + 1;
                    h = m_ep - m_sp + 1;
                    e.addr = ADDR_W'((m_sp + (m_k / w) % h) * H_RES + m_sc + m_k % w);
                    e.data = d;
                    e.last = ((m_k % (w * h)) == w * h - 1);
                    m_k++;
                    exp_q.push_back(e);
                    if (e.last) exp_lasts++;
                    last_addr = e.addr;
                    last_data = d;
                    pushed = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    // Called just after a rising edge; returns just after the edge on which the word was taken.
    task automatic send(input logic mode, input logic [15:0] d);
        int n = 0;
        bit pushed;
        if (rand_ready) i_wr_ready = ($urandom_range(0, 3) != 0);
        i_valid = 1'b1;
        i_mode  = mode;
        i_data  = d;
        @(negedge clk);
        while (!o_ready && n < 300) begin
            @(posedge clk); #1;
            i_wr_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        check("o_ready_wait", o_ready, 1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        model_step(mode, d, pushed);
        if (pushed) begin
            check("latency_valid", o_wr_valid, 1);
            check("latency_addr", o_wr_addr, last_addr);
            check("latency_data", o_wr_data, last_data);
        end
    endtask

    task automatic drain();
        i_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("exp_queue_empty", exp_q.size(), 0);
        check("frame_done_count", done_cnt, exp_lasts);
    endtask

    // RAM-side scoreboard: every transfer must match the next expected pixel, in order.
    always @(negedge clk) begin
        wr_t e;
        if (mon_en) begin
            check("frame_done", o_frame_done, exp_done);
            if (o_frame_done) done_cnt++;
            exp_done = 1'b0;
            if (o_wr_valid && i_wr_ready) begin
                check("write_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("ram_addr", o_wr_addr, e.addr);
                    check("ram_data", o_wr_data, e.data);
                    exp_done = e.last;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_data = '0; i_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_valid", o_wr_valid, 0);
        check("rst_frame_done", o_frame_done, 0);
        check("rst_addr", o_wr_addr, 0);
        check("rst_data", o_wr_data, 0);
        check("rst_ready", o_ready, 1);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Full-frame RAMWR straight out of reset.
        send(1'b1, 16'h2C00);
        send(1'b0, 16'hF800); check("t1_addr0", o_wr_addr, 0);
        send(1'b0, 16'h07E0); check("t1_addr1", o_wr_addr, 1);
        send(1'b0, 16'h001F); check("t1_addr2", o_wr_addr, 2);
        drain();

        // 3x2 window, wrap and frame_done.
        send(1'b1, 16'h2A00); send(1'b0, 16'd10); send(1'b0, 16'd12);
        send(1'b1, 16'h2B00); send(1'b0, 16'd5);  send(1'b0, 16'd6);
        send(1'b1, 16'h2C00);
        for (int k = 0; k < 6; k++) send(1'b0, 16'(16'hA000 + k));
        check("t2_addr_last", o_wr_addr, 1932);
        drain();
        check("t2_done_once", done_cnt, 1);
        send(1'b0, 16'hA006);
        check("t2_wrap_addr", o_wr_addr, 1610);

        // RAM stall for four cycles mid-stream.
        send(1'b0, 16'hB000);
        i_wr_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("stall_ready", o_ready, 0);
            check("stall_valid", o_wr_valid, 1);
            check("stall_addr", o_wr_addr, last_addr);
            check("stall_data", o_wr_data, last_data);
            @(posedge clk); #1;
        end
        i_wr_ready = 1'b1;
        for (int k = 0; k < 3; k++) send(1'b0, 16'(16'hB001 + k));
        drain();

        // Clamping and start>end ordering on full rows.
        send(1'b1, 16'h2B00); send(1'b0, 16'd0); send(1'b0, 16'd239);
        send(1'b1, 16'h2A00); send(1'b0, 16'd400); send(1'b0, 16'd500);
        send(1'b1, 16'h2C00);
        send(1'b0, 16'h1111); check("clamp_addr0", o_wr_addr, 319);
        send(1'b0, 16'h2222); check("clamp_addr1", o_wr_addr, 639);
        send(1'b1, 16'h2A00); send(1'b0, 16'd50); send(1'b0, 16'd20);
        send(1'b1, 16'h2C00);
        send(1'b0, 16'h3333); check("order_addr0", o_wr_addr, 50);
        send(1'b0, 16'h4444); check("order_addr1", o_wr_addr, 370);

        // Mid-stream command: 0x1234 becomes SC (clamped), never a pixel.
        send(1'b1, 16'h2A00);
        send(1'b0, 16'h1234);
        send(1'b0, 16'd0);
        drain();
        send(1'b1, 16'h2C00);
        send(1'b0, 16'h5555); check("abort_addr", o_wr_addr, 319);

        // Reset with a write pending discards it.
        send(1'b0, 16'hBEEF);
        i_wr_ready = 1'b0;
        check("pre_rst_valid", o_wr_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", o_wr_valid, 0);
        exp_q.delete();
        model_reset_window();
        m_st = M_IDLE;
        exp_done = 1'b0;
        reset = 1'b0;
        drain();

        // SWRESET opcode.
        send(1'b1, 16'h2A00); send(1'b0, 16'd10); send(1'b0, 16'd12);
        send(1'b1, 16'h0100);
        send(1'b1, 16'h2C00);
        send(1'b0, 16'h6666);
`ifdef LCD_WINDOW_CTRL_SWRESET_EN
        check("swreset_addr", o_wr_addr, 0);
`else
        check("swreset_addr", o_wr_addr, 10);
`endif
        drain();

        // Random windows, random RAM back-pressure, occasional stray opcodes.
        rand_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            int sc, ec, sp, ep, npix;
            sc = $urandom_range(0, 330);
            ec = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 330) : sc + $urandom_range(0, 4);
            sp = $urandom_range(0, 250);
            ep = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 250) : sp + $urandom_range(0, 3);
            send(1'b1, {8'h2A, 8'($urandom)}); send(1'b0, 16'(sc)); send(1'b0, 16'(ec));
            send(1'b1, {8'h2B, 8'($urandom)}); send(1'b0, 16'(sp)); send(1'b0, 16'(ep));
            if ($urandom_range(0, 4) == 0) send(1'b1, {8'($urandom), 8'h00});
            send(1'b1, {8'h2C, 8'($urandom)});
            npix = $urandom_range(1, 30);
            for (int k = 0; k < npix; k++) send(1'b0, 16'($urandom));
        end
        rand_ready = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
